// File: rtl/mem_axi_mux_if.sv
`timescale 1ns/1ps
// axi_bus_t: AXI4 bus bundle shared by the L2, PCIe and memory-side ports.
// Modport names give the partner attached to the port that uses them:
//   master - this side faces an AXI master (requests come in, responses go out)
//   slave  - this side faces an AXI slave  (requests go out, responses come in)
// Parameters: ADDR_W address width, DATA_W data width, ID_W transaction ID width.
interface axi_bus_t #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 16
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid,  output wready,
        output bid, bresp, bvalid,           input  bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport slave (
        output awid, awaddr, awlen, awvalid, input  awready,
        output wdata, wstrb, wlast, wvalid,  input  wready,
        input  bid, bresp, bvalid,           output bready,
        output arid, araddr, arlen, arvalid, input  arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/mem_axi_mux.sv
`timescale 1ns/1ps
// mem_axi_mux: N-to-1 AXI4 multiplexer merging several requesters (L2 slices,
// PCIe DMA, debug) onto one DDR controller port.
//   - AR and AW are arbitrated independently (round-robin by default).
//   - Downstream IDs carry the master index in their top IDX_W bits; R/B
//     responses are steered back by that tag, so out-of-order returns work.
//   - A write-order FIFO of granted AW indices steers W beats to the master
//     whose AW went out first.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   m    - array of N_MASTERS upstream ports (facing the masters)
//   mem  - downstream port to the memory controller
// Build option: define MEM_AXI_MUX_FIXED_PRIO_EN for fixed priority (lowest
// index wins) on both AR and AW instead of round-robin.
module mem_axi_mux #(
    parameter int N_MASTERS = 2,
    parameter int ID_W      = 16,
    parameter int IDX_W     = $clog2(N_MASTERS),
    parameter int WQ_DEPTH  = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64
) (
    input  logic     clk,
    input  logic     rstn,
    axi_bus_t.master m [N_MASTERS],
    axi_bus_t.slave  mem
);
    localparam int WQ_AW = $clog2(WQ_DEPTH);

    // Round-robin pick: first requester at or after ptr, wrapping.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!found && req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Fixed priority pick: lowest requesting index.
    function automatic logic [IDX_W-1:0] fixed_pick(input logic [N_MASTERS-1:0] req);
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && req[k]) begin
                pick  = IDX_W'(k);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Index following g, wrapping at N_MASTERS.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == N_MASTERS - 1) ? {IDX_W{1'b0}} : g + IDX_W'(1);
    endfunction

    // Upstream request signals gathered into arrays so they can be indexed
    // by a runtime grant.
    logic [N_MASTERS-1:0] m_arvalid_s;
    logic [N_MASTERS-1:0] m_awvalid_s;
    logic [N_MASTERS-1:0] m_wvalid_s;
    logic [N_MASTERS-1:0] m_wlast_s;
    logic [N_MASTERS-1:0] m_rready_s;
    logic [N_MASTERS-1:0] m_bready_s;
    logic [ID_W-1:0]      m_arid_s   [N_MASTERS];
    logic [ADDR_W-1:0]    m_araddr_s [N_MASTERS];
    logic [7:0]           m_arlen_s  [N_MASTERS];
    logic [ID_W-1:0]      m_awid_s   [N_MASTERS];
    logic [ADDR_W-1:0]    m_awaddr_s [N_MASTERS];
    logic [7:0]           m_awlen_s  [N_MASTERS];
    logic [DATA_W-1:0]    m_wdata_s  [N_MASTERS];
    logic [DATA_W/8-1:0]  m_wstrb_s  [N_MASTERS];
    // Upper master ID bits are dropped by the tagging scheme.
    logic [2*N_MASTERS*IDX_W-1:0] unused_id_bits_s;

    // AR channel state
    logic             ar_lock_q;
    logic [IDX_W-1:0] ar_gnt_q;
    logic [IDX_W-1:0] ar_pick_s;
    logic [IDX_W-1:0] ar_gnt_s;
    logic             mem_arvalid_s;
    logic             ar_hs_s;

    // AW channel state
    logic             aw_lock_q;
    logic [IDX_W-1:0] aw_gnt_q;
    logic [IDX_W-1:0] aw_pick_s;
    logic [IDX_W-1:0] aw_gnt_s;
    logic             mem_awvalid_s;
    logic             aw_hs_s;

    // Write-order FIFO
    logic [IDX_W-1:0] wq_mem_q [WQ_DEPTH];
    logic [WQ_AW-1:0] wq_wr_q;
    logic [WQ_AW-1:0] wq_rd_q;
    logic [WQ_AW:0]   wq_cnt_q;
    logic             wq_full_s;
    logic             wq_empty_s;
    logic             wq_push_s;
    logic             wq_pop_s;
    logic [IDX_W-1:0] wq_head_s;
    logic             mem_wvalid_s;

    // Response routing
    logic [IDX_W-1:0] rid_tag_s;
    logic [IDX_W-1:0] bid_tag_s;
    logic             r_ok_s;
    logic             b_ok_s;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        assign m_arvalid_s[i] = m[i].arvalid;
        assign m_awvalid_s[i] = m[i].awvalid;
        assign m_wvalid_s[i]  = m[i].wvalid;
        assign m_wlast_s[i]   = m[i].wlast;
        assign m_rready_s[i]  = m[i].rready;
        assign m_bready_s[i]  = m[i].bready;
        assign m_arid_s[i]    = m[i].arid;
        assign m_araddr_s[i]  = m[i].araddr;
        assign m_arlen_s[i]   = m[i].arlen;
        assign m_awid_s[i]    = m[i].awid;
        assign m_awaddr_s[i]  = m[i].awaddr;
        assign m_awlen_s[i]   = m[i].awlen;
        assign m_wdata_s[i]   = m[i].wdata;
        assign m_wstrb_s[i]   = m[i].wstrb;
        assign unused_id_bits_s[2*i*IDX_W +: 2*IDX_W] =
            {m[i].arid[ID_W-1 -: IDX_W], m[i].awid[ID_W-1 -: IDX_W]};

        // Ready only to the granted master; the AW ready is also held off
        // while the write-order FIFO has no room.
        assign m[i].arready = rstn && (ar_gnt_s == IDX_W'(i)) && mem.arready;
        assign m[i].awready = rstn && !wq_full_s && (aw_gnt_s == IDX_W'(i)) && mem.awready;
        assign m[i].wready  = rstn && !wq_empty_s && (wq_head_s == IDX_W'(i)) && mem.wready;

        assign m[i].rvalid  = rstn && mem.rvalid && r_ok_s && (rid_tag_s == IDX_W'(i));
        assign m[i].rid     = {{IDX_W{1'b0}}, mem.rid[ID_W-IDX_W-1:0]};
        assign m[i].rdata   = mem.rdata;
        assign m[i].rresp   = mem.rresp;
        assign m[i].rlast   = mem.rlast;

        assign m[i].bvalid  = rstn && mem.bvalid && b_ok_s && (bid_tag_s == IDX_W'(i));
        assign m[i].bid     = {{IDX_W{1'b0}}, mem.bid[ID_W-IDX_W-1:0]};
        assign m[i].bresp   = mem.bresp;
    end

`ifdef MEM_AXI_MUX_FIXED_PRIO_EN
    assign ar_pick_s = fixed_pick(m_arvalid_s);
    assign aw_pick_s = fixed_pick(m_awvalid_s);
`else
    logic [IDX_W-1:0] ar_ptr_q;
    logic [IDX_W-1:0] aw_ptr_q;

    assign ar_pick_s = rr_pick(m_arvalid_s, ar_ptr_q);
    assign aw_pick_s = rr_pick(m_awvalid_s, aw_ptr_q);

    // Round-robin pointers: restart after the master just granted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ar_ptr_q <= {IDX_W{1'b0}};
            aw_ptr_q <= {IDX_W{1'b0}};
        end else begin
            if (ar_hs_s) begin
                ar_ptr_q <= next_idx(ar_gnt_s);
            end
            if (aw_hs_s) begin
                aw_ptr_q <= next_idx(aw_gnt_s);
            end
        end
    end
`endif

    // ---------------- AR ----------------
    // While a presented request is stalled the previous grant is reused so
    // the downstream request stays stable.
    assign ar_gnt_s      = ar_lock_q ? ar_gnt_q : ar_pick_s;
    assign mem_arvalid_s = rstn && m_arvalid_s[ar_gnt_s];
    assign ar_hs_s       = mem_arvalid_s && mem.arready;

    assign mem.arvalid = mem_arvalid_s;
    assign mem.arid    = {ar_gnt_s, m_arid_s[ar_gnt_s][ID_W-IDX_W-1:0]};
    assign mem.araddr  = m_araddr_s[ar_gnt_s];
    assign mem.arlen   = m_arlen_s[ar_gnt_s];

    // ---------------- AW ----------------
    assign aw_gnt_s      = aw_lock_q ? aw_gnt_q : aw_pick_s;
    assign mem_awvalid_s = rstn && !wq_full_s && m_awvalid_s[aw_gnt_s];
    assign aw_hs_s       = mem_awvalid_s && mem.awready;

    assign mem.awvalid = mem_awvalid_s;
    assign mem.awid    = {aw_gnt_s, m_awid_s[aw_gnt_s][ID_W-IDX_W-1:0]};
    assign mem.awaddr  = m_awaddr_s[aw_gnt_s];
    assign mem.awlen   = m_awlen_s[aw_gnt_s];

    // Grant lock for both address channels.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ar_lock_q <= 1'b0;
            ar_gnt_q  <= {IDX_W{1'b0}};
            aw_lock_q <= 1'b0;
            aw_gnt_q  <= {IDX_W{1'b0}};
        end else begin
            ar_lock_q <= mem_arvalid_s && !mem.arready;
            ar_gnt_q  <= ar_gnt_s;
            aw_lock_q <= mem_awvalid_s && !mem.awready;
            aw_gnt_q  <= aw_gnt_s;
        end
    end

    // ---------------- W ----------------
    // The head entry names the master whose burst goes next; W is closed
    // while no AW is pending, so no beat can overtake its address.
    assign wq_full_s    = (wq_cnt_q == (WQ_AW+1)'(WQ_DEPTH));
    assign wq_empty_s   = (wq_cnt_q == (WQ_AW+1)'(0));
    assign wq_head_s    = wq_mem_q[wq_rd_q];
    assign mem_wvalid_s = rstn && !wq_empty_s && m_wvalid_s[wq_head_s];
    assign wq_push_s    = aw_hs_s;
    assign wq_pop_s     = mem_wvalid_s && mem.wready && m_wlast_s[wq_head_s];

    assign mem.wvalid = mem_wvalid_s;
    assign mem.wdata  = m_wdata_s[wq_head_s];
    assign mem.wstrb  = m_wstrb_s[wq_head_s];
    assign mem.wlast  = m_wlast_s[wq_head_s];

    // Write-order FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wq_wr_q  <= {WQ_AW{1'b0}};
            wq_rd_q  <= {WQ_AW{1'b0}};
            wq_cnt_q <= {(WQ_AW+1){1'b0}};
        end else begin
            if (wq_push_s) begin
                wq_wr_q <= wq_wr_q + WQ_AW'(1);
            end
            if (wq_pop_s) begin
                wq_rd_q <= wq_rd_q + WQ_AW'(1);
            end
            case ({wq_push_s, wq_pop_s})
                2'b10:   wq_cnt_q <= wq_cnt_q + (WQ_AW+1)'(1);
                2'b01:   wq_cnt_q <= wq_cnt_q - (WQ_AW+1)'(1);
                default: wq_cnt_q <= wq_cnt_q;
            endcase
        end
    end

    // Write-order FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wq_push_s) begin
            wq_mem_q[wq_wr_q] <= aw_gnt_s;
        end
    end

    // ---------------- R / B ----------------
    // Tags naming no master are accepted (ready=1) and discarded.
    assign rid_tag_s = mem.rid[ID_W-1 -: IDX_W];
    assign bid_tag_s = mem.bid[ID_W-1 -: IDX_W];
    assign r_ok_s    = (int'(rid_tag_s) < N_MASTERS);
    assign b_ok_s    = (int'(bid_tag_s) < N_MASTERS);

    assign mem.rready = rstn && (r_ok_s ? m_rready_s[rid_tag_s] : 1'b1);
    assign mem.bready = rstn && (b_ok_s ? m_bready_s[bid_tag_s] : 1'b1);

    mem_axi_mux_chk u_chk (
        .clk      (clk),
        .rstn     (rstn),
        .r_drop_i (rstn && mem.rvalid && !r_ok_s),
        .b_drop_i (rstn && mem.bvalid && !b_ok_s)
    );
endmodule

// mem_axi_mux_chk: simulation watchdog for responses whose ID tag names no
// master. The sticky flag stays set until reset so a single dropped beat is
// never lost.
// Ports: clk, rstn, r_drop_i / b_drop_i - a response is being discarded.
module mem_axi_mux_chk (
    input logic clk,
    input logic rstn,
    input logic r_drop_i,
    input logic b_drop_i
);
    logic err_drop_q;

    // Sticky record of any discarded response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= err_drop_q || r_drop_i || b_drop_i;
        end
    end

    a_no_drop: assert property (@(posedge clk) disable iff (!rstn) !err_drop_q);
endmodule
